// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Sequencing execute stage for the ALU datapath. A request (A, B, Op) is
//   accepted over a valid/ready handshake and latched. The latched operands
//   feed the combinational function units (AND/OR/XOR/ADD/SUB). Shifts run
//   iteratively, one bit per cycle. The result and its zero flag are held
//   in registers until the writeback stage takes them.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   in_valid   request present            in_ready   stage can accept
//   A, B       operands (B[SHW-1:0] = shift amount)
//   Op         000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB,
//              101 SLL, 110 SRL, 111 SRA
//   out_valid  result available           out_ready  downstream accepts
//   Out        registered result          Zero       1 when Out == 0
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Zero
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       op_r;
  logic [SHW-1:0]   cnt_r;
  logic             arm_r;     // first EXEC cycle: capture function-unit output
  logic [WIDTH-1:0] work_r;    // working register (result or shifting value)
  logic [WIDTH-1:0] out_r;
  logic             zero_r;

  logic [WIDTH-1:0] fu_result_s;
  logic [WIDTH-1:0] shift_step_s;
  logic             is_shift_s;

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}});
  endfunction

  // Function units driven from the latched operands; shifts start from A.
  always_comb begin
    fu_result_s = a_r;
    case (op_r)
      OP_AND:  fu_result_s = a_r & b_r;
      OP_OR:   fu_result_s = a_r | b_r;
      OP_XOR:  fu_result_s = a_r ^ b_r;
      OP_ADD:  fu_result_s = a_r + b_r;
      OP_SUB:  fu_result_s = a_r - b_r;
      default: fu_result_s = a_r;
    endcase
  end

  // One-bit shift step of the working register; SRA refills from latched A's sign.
  always_comb begin
    shift_step_s = work_r;
    case (op_r)
      OP_SLL:  shift_step_s = {work_r[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_step_s = {1'b0, work_r[WIDTH-1:1]};
      OP_SRA:  shift_step_s = {a_r[WIDTH-1], work_r[WIDTH-1:1]};
      default: shift_step_s = work_r;
    endcase
  end

  // Shift-class decode of the latched opcode.
  always_comb begin
    if ((op_r == OP_SLL) || (op_r == OP_SRL) || (op_r == OP_SRA)) begin
      is_shift_s = 1'b1;
    end else begin
      is_shift_s = 1'b0;
    end
  end

  // Handshake flags come straight from the state register.
  assign in_ready  = (state_r == S_IDLE);
  assign out_valid = (state_r == S_DONE);
  assign Out       = out_r;
  assign Zero      = zero_r;

  // Sequencer: accept, execute (capture then shift/finish), hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      op_r    <= 3'b000;
      cnt_r   <= {SHW{1'b0}};
      arm_r   <= 1'b0;
      work_r  <= {WIDTH{1'b0}};
      out_r   <= {WIDTH{1'b0}};
      zero_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            a_r     <= A;
            b_r     <= B;
            op_r    <= Op;
            cnt_r   <= B[SHW-1:0];
            arm_r   <= 1'b1;
            state_r <= S_EXEC;
          end
        end
        S_EXEC: begin
          // The capture cycle keeps the adder and the zero detect in
          // separate cycles; the shift loop starts after it.
          if (arm_r) begin
            work_r <= fu_result_s;
            arm_r  <= 1'b0;
          end else if (is_shift_s && (cnt_r != {SHW{1'b0}})) begin
            work_r <= shift_step_s;
            cnt_r  <= cnt_r - SHW'(1);
          end else begin
            out_r   <= work_r;
            zero_r  <= is_zero(work_r);
            state_r <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  Op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Out;
  logic        Zero;

  int checks = 0;
  int errors = 0;

  alu_exec_stage #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Op(Op),
    .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out), .Zero(Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request from an IDLE cycle; lat = edges from accept to out_valid (0 = timeout).
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, output int lat);
    A = a; B = b; Op = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = 32'hA5A5A5A5; B = 32'h5A5A5A5A; Op = OP_SRA;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (Out !== 32'h0)       begin errors++; $display("FAIL rst_out got %h want 00000000", Out); end
    checks++; if (Zero !== 1'b0)       begin errors++; $display("FAIL rst_zero got %b want 0", Zero); end
  endtask

  task automatic test_xor();
    int lat;
    issue(32'hF0F0F0F0, 32'hFF00FF00, OP_XOR, lat);
    checks++; if (lat !== 2)           begin errors++; $display("FAIL xor_latency got %0d want 2", lat); end
    checks++; if (Out !== 32'h0FF00FF0) begin errors++; $display("FAIL xor_out got %h want 0ff00ff0", Out); end
    checks++; if (Zero !== 1'b0)       begin errors++; $display("FAIL xor_zero got %b want 0", Zero); end
    checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL xor_ready_done got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL xor_after_hs got rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_zero_flag();
    int lat;
    issue(32'h12345678, 32'h12345678, OP_XOR, lat);
    checks++; if (Out !== 32'h0 || Zero !== 1'b1) begin
      errors++; $display("FAIL zero_xor got %h/%b want 00000000/1", Out, Zero);
    end
    @(posedge clk); #1;
    issue(32'hFFFFFFFF, 32'h00000001, OP_ADD, lat);
    checks++; if (Out !== 32'h0 || Zero !== 1'b1) begin
      errors++; $display("FAIL zero_add_wrap got %h/%b want 00000000/1", Out, Zero);
    end
    @(posedge clk); #1;
    issue(32'h00000003, 32'h00000005, OP_SUB, lat);
    checks++; if (Out !== 32'hFFFFFFFE || Zero !== 1'b0) begin
      errors++; $display("FAIL sub_neg got %h/%b want fffffffe/0", Out, Zero);
    end
    checks++; if (lat !== 2) begin errors++; $display("FAIL sub_latency got %0d want 2", lat); end
    @(posedge clk); #1;
    issue(32'h0000F0F0, 32'h0000FF00, OP_AND, lat);
    checks++; if (Out !== 32'h0000F000) begin errors++; $display("FAIL and_out got %h want 0000f000", Out); end
    @(posedge clk); #1;
    issue(32'h0000F0F0, 32'h0000FF00, OP_OR, lat);
    checks++; if (Out !== 32'h0000FFF0) begin errors++; $display("FAIL or_out got %h want 0000fff0", Out); end
    @(posedge clk); #1;
  endtask

  task automatic test_shifts();
    int lat;
    issue(32'h80000000, 32'h00000004, OP_SRA, lat);
    checks++; if (lat !== 6)            begin errors++; $display("FAIL sra_latency got %0d want 6", lat); end
    checks++; if (Out !== 32'hF8000000) begin errors++; $display("FAIL sra_out got %h want f8000000", Out); end
    @(posedge clk); #1;
    issue(32'h80000000, 32'h00000004, OP_SRL, lat);
    checks++; if (lat !== 6)            begin errors++; $display("FAIL srl_latency got %0d want 6", lat); end
    checks++; if (Out !== 32'h08000000) begin errors++; $display("FAIL srl_out got %h want 08000000", Out); end
    @(posedge clk); #1;
    issue(32'h00000001, 32'h0000003F, OP_SLL, lat);
    checks++; if (lat !== 33)           begin errors++; $display("FAIL sll31_latency got %0d want 33", lat); end
    checks++; if (Out !== 32'h80000000) begin errors++; $display("FAIL sll31_out got %h want 80000000", Out); end
    @(posedge clk); #1;
    issue(32'hDEADBEEF, 32'h00000020, OP_SLL, lat);
    checks++; if (lat !== 2)            begin errors++; $display("FAIL shift0_latency got %0d want 2", lat); end
    checks++; if (Out !== 32'hDEADBEEF || Zero !== 1'b0) begin
      errors++; $display("FAIL shift0_out got %h/%b want deadbeef/0", Out, Zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    issue(32'h00000005, 32'h00000007, OP_ADD, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL bp_latency got %0d want 2", lat); end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      A  = 32'h11111111 * (i + 1);
      B  = 32'h01010101 * (i + 3);
      Op = 3'(i);
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || Out !== 32'h0000000C || Zero !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got ov=%b rdy=%b out=%h z=%b want ov=1 rdy=0 out=0000000c z=0",
                           i, out_valid, in_ready, Out, Zero);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || Out !== 32'h0000000C) begin
      errors++; $display("FAIL bp_single got ov=%b out=%h want ov=0 out=0000000c", out_valid, Out);
    end
  endtask

  task automatic test_reset_mid();
    int  lat;
    logic seen;
    A = 32'hFFFF0000; B = 32'h00000014; Op = OP_SRL; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_flags got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
    end
    checks++; if (Out !== 32'h0 || Zero !== 1'b0) begin
      errors++; $display("FAIL midrst_out got %h/%b want 00000000/0", Out, Zero);
    end
    #3 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_ghost got out_valid=1 want 0"); end
    issue(32'h000000FF, 32'h0000000F, OP_AND, lat);
    checks++; if (lat !== 2 || Out !== 32'h0000000F) begin
      errors++; $display("FAIL midrst_and got lat=%0d out=%h want lat=2 out=0000000f", lat, Out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ra [3];
    logic [31:0] rb [3];
    logic [31:0] rexp [3];
    logic [2:0]  rop [3];
    int   n_acc;
    int   n_out;
    int   last_hs;
    logic pre_ready;
    logic pre_valid;
    ra[0] = 32'h000000F0; rb[0] = 32'h0000000F; rop[0] = OP_OR;  rexp[0] = 32'h000000FF;
    ra[1] = 32'h0000000A; rb[1] = 32'h00000003; rop[1] = OP_SUB; rexp[1] = 32'h00000007;
    ra[2] = 32'h00000003; rb[2] = 32'hFFFFFFE2; rop[2] = OP_SLL; rexp[2] = 32'h0000000C;
    out_ready = 1'b1;
    n_acc = 0; n_out = 0; last_hs = -10;
    A = ra[0]; B = rb[0]; Op = rop[0]; in_valid = 1'b1;
    for (int c = 1; c <= 200 && n_out < 3; c++) begin
      pre_ready = in_ready;
      pre_valid = out_valid;
      @(posedge clk); #1;
      if (pre_valid) begin
        checks++; if (Out !== rexp[n_out]) begin
          errors++; $display("FAIL b2b_out%0d got %h want %h", n_out, Out, rexp[n_out]);
        end
        n_out++;
        last_hs = c;
      end
      if (pre_ready && in_valid) begin
        if (n_acc > 0) begin
          checks++; if (c !== last_hs + 1) begin
            errors++; $display("FAIL b2b_accept%0d got edge %0d want %0d", n_acc, c, last_hs + 1);
          end
        end
        n_acc++;
        if (n_acc < 3) begin
          A = ra[n_acc]; B = rb[n_acc]; Op = rop[n_acc];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    checks++; if (n_out !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", n_out); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = 32'h0; B = 32'h0; Op = 3'b000;
    #12;
    test_reset();
    #8 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_xor();
    test_zero_flag();
    test_shifts();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Sequencing execute stage for the 32-bit ALU datapath. It accepts an operand pair and opcode over a valid/ready handshake, latches them, and drives the latched operands into the combinational function units (AND, OR, XOR, ADD/SUB). It performs shifts iteratively, one bit per cycle. It registers the selected result with a zero flag and holds it until the downstream writeback stage consumes it.

## Interface
- WIDTH, 32, datapath width; must be a power of two and at least 2.
- SHW, $clog2(WIDTH), shift-amount width (5 for WIDTH=32).

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active low.
- in_valid  input  1  operand request present.
- in_ready  output  1  stage can accept a request.
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand; B[SHW-1:0] is the shift amount for shifts.
- Op  input  3  opcode:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 ADD
  - 100 SUB (A−B)
  - 101 SLL
  - 110 SRL
  - 111 SRA
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- Out  output  WIDTH  registered result.
- Zero  output  1  registered flag; 1 when Out == 0.

## Operation
- **States**
  - IDLE: in_ready=1, out_valid=0.
  - EXEC: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- **Transitions**
  - IDLE → EXEC on in_valid && in_ready. A, B and Op are latched, and the shift counter is loaded with B[SHW-1:0].
  - EXEC, non-shift op: the result is registered into Out/Zero. Go to DONE.
  - EXEC, shift op with counter ≠ 0: the working register shifts by one bit and the counter decrements. Stay in EXEC.
  - EXEC, shift op with counter == 0: the working register is registered into Out/Zero. Go to DONE.
  - DONE → IDLE on out_ready. Out and Zero hold their values until the next result is registered.
- **Arithmetic**
  - ADD and SUB wrap modulo 2^WIDTH; there is no carry or overflow output.
  - AND, OR and XOR are bitwise on the latched A and B.
- **Shifts**
  - SLL and SRL fill with 0.
  - SRA replicates latched A[WIDTH-1] on every step.
  - Only B[SHW-1:0] is used; the upper bits of B are ignored.
- **Inputs outside IDLE:** in_valid, A, B and Op are ignored. The latched operands stay stable for the whole operation.
- **Reset values:** state=IDLE, in_ready=1, out_valid=0, Out=0, Zero=0, shift counter=0, operand latches=0.
- **Reset mid-operation:** asserting rst_n low in EXEC or DONE aborts the operation immediately. The result is discarded, and no out_valid pulse appears after reset is released.
- **Zero validity:** Zero is computed from the value being registered into Out, so Out and Zero always update together. Zero is meaningful only while out_valid=1.

## Timing
- All state and outputs update on the rising clk edge, except asynchronous reset.
- in_ready and out_valid are decoded directly from the state register, with no combinational path from in_valid or out_ready.
- **Latency**, with the accept edge at cycle k:
  - Non-shift op: out_valid rises at edge k+2.
  - Shift by n: out_valid rises at edge k+2+n.
  - Shift by 0 behaves like a non-shift op.
  - Maximum latency is WIDTH+1 cycles from accept.
- **Throughput:** one request in flight.
  - After the output handshake at edge m, in_ready=1 from edge m.
  - The earliest next accept is at edge m+1.
- **Simultaneous events:** in_valid asserted in DONE while out_ready=1 is not accepted in that cycle; it must be presented again in IDLE.
- **Backpressure:** out_ready may stay low indefinitely. Out, Zero and out_valid hold steady throughout.

## Test plan
- **XOR:** A=0xF0F0F0F0, B=0xFF00FF00, Op=010, out_ready=1 → accepted at edge k; out_valid=1 at edge k+2 with Out=0x0FF00FF0, Zero=0; in_ready=1 from the handshake edge.
- **Zero flag:** XOR with A=B=0x12345678 gives Out=0, Zero=1. ADD with A=0xFFFFFFFF, B=1 gives Out=0, Zero=1 (wrap). SUB with A=3, B=5 gives Out=0xFFFFFFFE, Zero=0.
- **Shifts:**
  - SRA A=0x80000000, B=4 → Out=0xF8000000 at edge k+6.
  - SRL same operands → 0x08000000.
  - SLL A=1, B=0x0000003F (amount 31) → 0x80000000 at edge k+33.
  - Shift by 0 → Out=A at edge k+2.
- **Backpressure:** hold out_ready=0 for 5 cycles in DONE while toggling in_valid, A, B and Op → Out, Zero and out_valid stay constant and in_ready=0. Raising out_ready completes exactly one transfer.
- **Reset:**
  - Assert rst_n=0 midway through SRL by 20 → out_valid=0, in_ready=1, Out=0 and Zero=0 immediately.
  - After release, no result appears until a new request.
  - A new AND with A=0xFF, B=0x0F returns 0x0F at accept+2.
- **Back-to-back requests:** in_valid held high with 3 queued requests and out_ready=1 → each accept occurs exactly 1 cycle after the previous output handshake; results appear in order.
